// File: rtl/snitch_icache_perf_cnt.sv
// Instruction-cache event counters with snapshot bank, sticky overflow bitmap and read port.
// Define SNITCH_ICACHE_PERF_SATURATE_EN to saturate counters on overflow (default wraps).
module snitch_icache_perf_cnt #(
    parameter int unsigned NR_FETCH_PORTS = 2,
    parameter int unsigned CNT_W          = 32
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    // per port: [4] miss, [3] hit, [2] prefetch, [1] double_hit, [0] stall
    input  logic [NR_FETCH_PORTS-1:0][4:0] l0_events_i,
    // [3] miss, [2] hit, [1] stall, [0] handler_stall
    input  logic [3:0]                     l1_events_i,
    input  logic                           cnt_en_i,
    input  logic                           clear_i,
    input  logic                           snap_i,
    input  logic                           rd_req_i,
    input  logic [3:0]                     rd_addr_i,
    input  logic                           rd_snap_i,
    output logic                           rd_gnt_o,
    output logic                           rsp_valid_o,
    output logic [CNT_W-1:0]               rsp_data_o,
    output logic                           rsp_err_o
);

    localparam int unsigned NCNT = 9;
    localparam int unsigned IW   = $clog2(NR_FETCH_PORTS + 1);
    localparam int unsigned SW   = CNT_W + 1;
    localparam int unsigned OVW  = (NCNT < CNT_W) ? NCNT : CNT_W;

    logic [NR_FETCH_PORTS-1:0][4:0] l0_q;
    logic [3:0]                     l1_q;
    logic                           en_q;
    logic                           clear_q;
    logic                           flush;

    logic [NCNT-1:0][IW-1:0]        inc;
    logic [NCNT-1:0][CNT_W-1:0]     cnt_q, cnt_d, snap_q;
    logic [NCNT-1:0]                ovf_q, ovf_d;
    logic [SW-1:0]                  sum;

    logic [CNT_W-1:0]               rd_data;
    logic                           rd_err;
    logic                           rsp_valid_q, rsp_err_q;
    logic [CNT_W-1:0]               rsp_data_q;

    // A clear flushes both the strobes of its own cycle and those of the following cycle.
    assign flush = clear_i | clear_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            l0_q    <= '0;
            l1_q    <= '0;
            en_q    <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            l0_q    <= flush ? '0 : l0_events_i;
            l1_q    <= flush ? '0 : l1_events_i;
            en_q    <= cnt_en_i;
            clear_q <= clear_i;
        end
    end

    always_comb begin
        inc = '0;
        if (en_q) begin
            for (int e = 0; e < 5; e++) begin
                for (int p = 0; p < int'(NR_FETCH_PORTS); p++) begin
                    inc[e] = inc[e] + IW'(l0_q[p][4-e]);
                end
            end
            for (int k = 0; k < 4; k++) begin
                inc[5+k] = IW'(l1_q[3-k]);
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        sum   = '0;
        for (int i = 0; i < int'(NCNT); i++) begin
            sum = {1'b0, cnt_q[i]} + SW'(inc[i]);
            if (sum[CNT_W]) begin
                ovf_d[i] = 1'b1;
`ifdef SNITCH_ICACHE_PERF_SATURATE_EN
                cnt_d[i] = '1;
`else
                cnt_d[i] = sum[CNT_W-1:0];
`endif
            end else begin
                cnt_d[i] = sum[CNT_W-1:0];
            end
        end
        if (clear_i) begin
            cnt_d = '0;
            ovf_d = '0;
        end
    end

    // Snapshot takes the register state of this cycle, i.e. before increment or clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            ovf_q  <= '0;
            snap_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            if (snap_i) begin
                snap_q <= cnt_q;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        if (rd_addr_i < 4'd9) begin
            rd_data = rd_snap_i ? snap_q[rd_addr_i] : cnt_q[rd_addr_i];
        end else if (rd_addr_i == 4'd9) begin
            for (int b = 0; b < int'(OVW); b++) begin
                rd_data[b] = ovf_q[b];
            end
        end else begin
            rd_err = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= rd_req_i;
            if (rd_req_i) begin
                rsp_data_q <= rd_data;
                rsp_err_q  <= rd_err;
            end
        end
    end

    assign rd_gnt_o    = ~rst_i;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_snitch_icache_perf_cnt.sv
// Scoreboard bench for snitch_icache_perf_cnt: a 2-port/32-bit instance and a 1-port/8-bit
// instance for the overflow boundary.
module tb_snitch_icache_perf_cnt;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [1:0][4:0] l0_a;
    logic [3:0]      l1_a;
    logic            en_a, clr_a, snap_a, req_a, rsnap_a;
    logic [3:0]      addr_a;
    logic            gnt_a, vld_a, err_a;
    logic [31:0]     data_a;

    logic [0:0][4:0] l0_b;
    logic [3:0]      l1_b;
    logic            en_b, clr_b, snap_b, req_b, rsnap_b;
    logic [3:0]      addr_b;
    logic            gnt_b, vld_b, err_b;
    logic [7:0]      data_b;

    snitch_icache_perf_cnt #(.NR_FETCH_PORTS(2), .CNT_W(32)) dut (
        .clk_i(clk), .rst_i(rst), .l0_events_i(l0_a), .l1_events_i(l1_a),
        .cnt_en_i(en_a), .clear_i(clr_a), .snap_i(snap_a), .rd_req_i(req_a),
        .rd_addr_i(addr_a), .rd_snap_i(rsnap_a), .rd_gnt_o(gnt_a),
        .rsp_valid_o(vld_a), .rsp_data_o(data_a), .rsp_err_o(err_a)
    );

    snitch_icache_perf_cnt #(.NR_FETCH_PORTS(1), .CNT_W(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .l0_events_i(l0_b), .l1_events_i(l1_b),
        .cnt_en_i(en_b), .clear_i(clr_b), .snap_i(snap_b), .rd_req_i(req_b),
        .rd_addr_i(addr_b), .rd_snap_i(rsnap_b), .rd_gnt_o(gnt_b),
        .rsp_valid_o(vld_b), .rsp_data_o(data_b), .rsp_err_o(err_b)
    );

    typedef struct {
        logic [63:0] data;
        logic        err;
        int          due;
        int          addr;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (vld_a) begin
            if (q_a.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL a_unexpected_rsp: got rsp_valid 1 expected 0 (cycle %0d)", cyc);
            end else begin
                ea = q_a.pop_front();
                check($sformatf("a_data_idx%0d", ea.addr), 64'(data_a), ea.data);
                check($sformatf("a_err_idx%0d", ea.addr), 64'(err_a), 64'(ea.err));
                check($sformatf("a_lat_idx%0d", ea.addr), 64'(cyc), 64'(ea.due));
            end
        end else if (q_a.size() != 0 && cyc >= q_a[0].due) begin
            ea = q_a.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL a_rsp_missing_idx%0d: got rsp_valid 0 expected 1", ea.addr);
        end
    end

    always @(negedge clk) begin
        if (vld_b) begin
            if (q_b.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL b_unexpected_rsp: got rsp_valid 1 expected 0 (cycle %0d)", cyc);
            end else begin
                eb = q_b.pop_front();
                check($sformatf("b_data_idx%0d", eb.addr), 64'(data_b), eb.data);
                check($sformatf("b_err_idx%0d", eb.addr), 64'(err_b), 64'(eb.err));
                check($sformatf("b_lat_idx%0d", eb.addr), 64'(cyc), 64'(eb.due));
            end
        end else if (q_b.size() != 0 && cyc >= q_b[0].due) begin
            eb = q_b.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL b_rsp_missing_idx%0d: got rsp_valid 0 expected 1", eb.addr);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd_a(input logic [3:0] a, input logic s, input logic [63:0] d, input logic e);
        req_a = 1'b1; addr_a = a; rsnap_a = s;
        q_a.push_back('{d, e, cyc + 1, int'(a)});
        idle(1);
        req_a = 1'b0; rsnap_a = 1'b0;
    endtask

    task automatic rd_b(input logic [3:0] a, input logic s, input logic [63:0] d, input logic e);
        req_b = 1'b1; addr_b = a; rsnap_b = s;
        q_b.push_back('{d, e, cyc + 1, int'(a)});
        idle(1);
        req_b = 1'b0; rsnap_b = 1'b0;
    endtask

    task automatic clear_a();
        clr_a = 1'b1;
        idle(1);
        clr_a = 1'b0;
    endtask

    logic [63:0] exp_sat;

    initial begin
        rst = 1'b1;
        l0_a = '0; l1_a = '0; en_a = 0; clr_a = 0; snap_a = 0; req_a = 0; addr_a = '0; rsnap_a = 0;
        l0_b = '0; l1_b = '0; en_b = 0; clr_b = 0; snap_b = 0; req_b = 0; addr_b = '0; rsnap_b = 0;
        @(posedge clk); #1;
        @(negedge clk);
        check("gnt_in_reset", 64'(gnt_a), 64'd0);
        check("vld_in_reset", 64'(vld_a), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("gnt_after_reset", 64'(gnt_a), 64'd1);

        // reset values, back-to-back
        for (int i = 0; i < 10; i++) rd_a(4'(i), 1'b0, 64'd0, 1'b0);
        idle(1);

        // two ports hitting for 10 cycles
        l0_a = {5'b01000, 5'b01000}; en_a = 1'b1;
        idle(10);
        l0_a = '0; en_a = 1'b0;
        idle(1);
        rd_a(4'd1, 1'b0, 64'd20, 1'b0);
        clear_a();
        idle(2);
        l0_a = {5'b01000, 5'b01000};
        idle(10);
        l0_a = '0;
        idle(1);
        rd_a(4'd1, 1'b0, 64'd0, 1'b0);

        // mixed fields: miss 3, prefetch 6, double_hit 3
        l0_a = {5'b00110, 5'b10100}; en_a = 1'b1;
        idle(3);
        l0_a = '0; en_a = 1'b0;
        idle(1);
        rd_a(4'd0, 1'b0, 64'd3, 1'b0);
        rd_a(4'd2, 1'b0, 64'd6, 1'b0);
        rd_a(4'd3, 1'b0, 64'd3, 1'b0);

        // clear flushes strobes of the clear cycle and the one after
        clear_a();
        idle(2);
        l1_a = 4'b1000; en_a = 1'b1;
        idle(5);
        l1_a = '0;
        idle(1);
        rd_a(4'd5, 1'b0, 64'd5, 1'b0);
        clr_a = 1'b1; l1_a = 4'b1000;
        idle(1);
        clr_a = 1'b0;
        idle(1);
        l1_a = '0;
        idle(1);
        rd_a(4'd5, 1'b0, 64'd0, 1'b0);
        rd_a(4'd9, 1'b0, 64'd0, 1'b0);
        clr_a = 1'b1; l1_a = 4'b1000;
        idle(1);
        clr_a = 1'b0;
        idle(2);
        l1_a = '0;
        idle(1);
        rd_a(4'd5, 1'b0, 64'd1, 1'b0);

        // snapshot alongside an increment, then clear leaves the snapshot
        l1_a = 4'b0100;
        idle(7);
        l1_a = '0;
        idle(1);
        snap_a = 1'b1; l1_a = 4'b0100;
        idle(1);
        snap_a = 1'b0; l1_a = '0;
        idle(1);
        rd_a(4'd6, 1'b0, 64'd8, 1'b0);
        rd_a(4'd6, 1'b1, 64'd7, 1'b0);
        clear_a();
        rd_a(4'd6, 1'b0, 64'd0, 1'b0);
        rd_a(4'd6, 1'b1, 64'd7, 1'b0);
        en_a = 1'b0;

        // back-to-back 0, 12, 9
        rd_a(4'd0, 1'b0, 64'd0, 1'b0);
        rd_a(4'd12, 1'b1, 64'd0, 1'b1);
        rd_a(4'd9, 1'b0, 64'd0, 1'b0);
        idle(1);

        // 8-bit counter overflow boundary
        l0_b = 5'b00001; en_b = 1'b1;
        idle(254);
        l0_b = '0; en_b = 1'b0;
        idle(1);
        rd_b(4'd4, 1'b0, 64'd254, 1'b0);
        rd_b(4'd9, 1'b0, 64'd0, 1'b0);
        l0_b = 5'b00001; en_b = 1'b1;
        idle(3);
        l0_b = '0; en_b = 1'b0;
        idle(1);
`ifdef SNITCH_ICACHE_PERF_SATURATE_EN
        exp_sat = 64'd255;
`else
        exp_sat = 64'd1;
`endif
        rd_b(4'd4, 1'b0, exp_sat, 1'b0);
        rd_b(4'd9, 1'b0, 64'h010, 1'b0);
        rd_b(4'd9, 1'b1, 64'h010, 1'b0);
        rd_b(4'd13, 1'b0, 64'd0, 1'b1);

        // request during reset is not granted and produces no response
        rst = 1'b1; req_a = 1'b1; addr_a = 4'd6;
        @(negedge clk);
        check("gnt_req_in_reset", 64'(gnt_a), 64'd0);
        @(posedge clk); #1;
        req_a = 1'b0;
        idle(1);
        rst = 1'b0;
        rd_a(4'd6, 1'b1, 64'd0, 1'b0);
        rd_a(4'd1, 1'b0, 64'd0, 1'b0);
        rd_b(4'd4, 1'b0, 64'd0, 1'b0);
        idle(3);

        check("a_queue_drained", 64'(q_a.size()), 64'd0);
        check("b_queue_drained", 64'(q_b.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
